// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer and empty-flag controller for an asynchronous FIFO.
// Keeps the binary and Gray read pointers and drives the memory read
// address. Produces registered empty / almost-empty flags and a fill
// level, using the write pointer already synchronized into rclk.
// Also holds a registered read-data stage and a sticky underflow flag.
//
// Handshake: a read is accepted on a rising rclk edge when rinc=1 and
// the registered rempty=0. The accepted word, taken from rmem_data at the
// current raddr, appears on rdata together with a one-cycle rvalid pulse
// right after that edge. rinc while empty is dropped and sets runderflow.
module rptr_empty_ctrl #(
  parameter int ADDR      = 3,
  parameter int DATA      = 8,
  parameter int AE_THRESH = 2
) (
  input  logic            rclk,
  input  logic            rrst,
  input  logic            rinc,
  input  logic [ADDR:0]   rq2_wptr,
  input  logic [DATA-1:0] rmem_data,
  input  logic            uf_clr,
  output logic [ADDR:0]   rptr,
  output logic [ADDR-1:0] raddr,
  output logic            rempty,
  output logic            ralmost_empty,
  output logic [ADDR:0]   rlevel,
  output logic [DATA-1:0] rdata,
  output logic            rvalid,
  output logic            runderflow
);

  localparam int PW = ADDR + 1;
  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] level_next;
  logic          rd_ok;

  // Accept decision and next pointer values, both binary and Gray.
  always_comb begin
    rd_ok      = rinc & ~rempty;
    rbinnext   = rbin + {{(PW-1){1'b0}}, rd_ok};
    rgraynext  = (rbinnext >> 1) ^ rbinnext;
  end

  // Convert the synchronized Gray write pointer to binary (XOR prefix from MSB).
  always_comb begin
    wbin_s = '0;
    wbin_s[PW-1] = rq2_wptr[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      wbin_s[i] = wbin_s[i+1] ^ rq2_wptr[i];
    end
  end

  // Occupancy after this edge; modulo arithmetic covers pointer wrap.
  always_comb begin
    level_next = wbin_s - rbinnext;
  end

  assign raddr = rbin[ADDR-1:0];

  // Pointer registers and status flags.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      rempty        <= (rgraynext == rq2_wptr);
      ralmost_empty <= (level_next <= AE_LIMIT);
      rlevel        <= level_next;
    end
  end

  // Read-data stage: capture the word at the current address on an accepted read.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok) begin
        rdata <= rmem_data;
      end
    end
  end

  // Sticky underflow; a new underflow outranks a simultaneous clear.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      runderflow <= 1'b0;
    end else if (rinc & rempty) begin
      runderflow <= 1'b1;
    end else if (uf_clr) begin
      runderflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Testbench for rptr_empty_ctrl: directed scenarios plus a random
// read/write stream, with a reference model and a read-data scoreboard.
module tb_rptr_empty_ctrl;

  localparam int ADDR = 3;
  localparam int DATA = 8;
  localparam int AE   = 2;
  localparam int PW   = ADDR + 1;

  logic            rclk = 1'b0;
  logic            rrst;
  logic            rinc;
  logic [PW-1:0]   rq2_wptr;
  logic [DATA-1:0] rmem_data;
  logic            uf_clr;
  logic [PW-1:0]   rptr;
  logic [ADDR-1:0] raddr;
  logic            rempty;
  logic            ralmost_empty;
  logic [PW-1:0]   rlevel;
  logic [DATA-1:0] rdata;
  logic            rvalid;
  logic            runderflow;

  logic [DATA-1:0] mem [0:(1<<ADDR)-1];
  assign rmem_data = mem[raddr];

  rptr_empty_ctrl #(.ADDR(ADDR), .DATA(DATA), .AE_THRESH(AE)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr),
    .rmem_data(rmem_data), .uf_clr(uf_clr), .rptr(rptr), .raddr(raddr),
    .rempty(rempty), .ralmost_empty(ralmost_empty), .rlevel(rlevel),
    .rdata(rdata), .rvalid(rvalid), .runderflow(runderflow)
  );

  // Clock / reset block
  always #5 rclk = ~rclk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA-1:0] exp_q[$];

  // Reference model state
  logic [PW-1:0] m_rbin;
  logic [PW-1:0] m_wbin;
  logic          m_empty;
  logic          m_uf;

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_w(input logic [PW-1:0] b);
    m_wbin   = b;
    rq2_wptr = gray(b);
  endtask

  task automatic model_reset();
    m_rbin  = '0;
    m_empty = 1'b1;
    m_uf    = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rptr"},   32'(rptr), 0);
    check_eq({tag, "_raddr"},  32'(raddr), 0);
    check_eq({tag, "_rempty"}, 32'(rempty), 1);
    check_eq({tag, "_ae"},     32'(ralmost_empty), 1);
    check_eq({tag, "_rlevel"}, 32'(rlevel), 0);
    check_eq({tag, "_rdata"},  32'(rdata), 0);
    check_eq({tag, "_rvalid"}, 32'(rvalid), 0);
    check_eq({tag, "_uf"},     32'(runderflow), 0);
  endtask

  // Driver: one clock with current inputs; model predicts, then outputs are checked.
  task automatic cycle();
    logic          rd_ok;
    logic [PW-1:0] lvl;
    check_eq("raddr", 32'(raddr), 32'(m_rbin[ADDR-1:0]));
    rd_ok = rinc & ~m_empty;
    if (rd_ok) exp_q.push_back(mem[m_rbin[ADDR-1:0]]);
    m_rbin  = m_rbin + PW'(rd_ok);
    m_uf    = (rinc & m_empty) ? 1'b1 : (uf_clr ? 1'b0 : m_uf);
    m_empty = (gray(m_rbin) == rq2_wptr);
    lvl     = m_wbin - m_rbin;
    @(posedge rclk);
    #1;
    check_eq("rptr",   32'(rptr), 32'(gray(m_rbin)));
    check_eq("rempty", 32'(rempty), 32'(m_empty));
    check_eq("rlevel", 32'(rlevel), 32'(lvl));
    check_eq("ae",     32'(ralmost_empty), 32'(lvl <= PW'(AE)));
    check_eq("uf",     32'(runderflow), 32'(m_uf));
    check_eq("rvalid", 32'(rvalid), 32'(rd_ok));
    if (rvalid) begin
      if (exp_q.size() == 0) begin
        check_eq("rdata_unexpected", 32'(rvalid), 0);
      end else begin
        check_eq("rdata", 32'(rdata), 32'(exp_q.pop_front()));
      end
    end
  endtask

  // Assert reset between edges and check outputs before any edge arrives.
  task automatic apply_reset(input string tag);
    rrst = 1'b1;
    #1;
    check_reset_outputs(tag);
    model_reset();
    rinc   = 1'b0;
    uf_clr = 1'b0;
    set_w('0);
    @(posedge rclk);
    #1;
    rrst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR); i++) mem[i] = '0;
    // Reset with rinc high and a nonzero write pointer: outputs need no edge.
    rrst     = 1'b1;
    rinc     = 1'b1;
    uf_clr   = 1'b0;
    rq2_wptr = 4'b0010;
    m_wbin   = 4'd3;
    #2;
    check_reset_outputs("reset");
    model_reset();
    rinc = 1'b0;
    set_w('0);
    @(posedge rclk);
    #1;
    rrst = 1'b0;

    // Fill visibility
    mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2;
    set_w(4'd3);
    cycle();
    check_eq("fill_rempty", 32'(rempty), 0);
    check_eq("fill_rlevel", 32'(rlevel), 3);
    check_eq("fill_ae",     32'(ralmost_empty), 0);

    // Drain three words
    rinc = 1'b1;
    cycle();
    check_eq("drain1_rdata",  32'(rdata), 32'h A0);
    check_eq("drain1_rlevel", 32'(rlevel), 2);
    check_eq("drain1_ae",     32'(ralmost_empty), 1);
    cycle();
    check_eq("drain2_rdata", 32'(rdata), 32'h A1);
    cycle();
    check_eq("drain3_rdata",  32'(rdata), 32'h A2);
    check_eq("drain3_rempty", 32'(rempty), 1);
    check_eq("drain3_rlevel", 32'(rlevel), 0);
    check_eq("drain3_rptr",   32'(rptr), 32'b0010);

    // Underflow: sticky, clearable, set beats clear
    cycle();
    cycle();
    check_eq("uf_set",  32'(runderflow), 1);
    check_eq("uf_rptr", 32'(rptr), 32'b0010);
    check_eq("uf_rvalid", 32'(rvalid), 0);
    rinc = 1'b0;
    cycle();
    check_eq("uf_hold", 32'(runderflow), 1);
    uf_clr = 1'b1;
    cycle();
    check_eq("uf_clr", 32'(runderflow), 0);
    uf_clr = 1'b0; rinc = 1'b1;
    cycle();
    uf_clr = 1'b1;
    cycle();
    check_eq("uf_set_wins", 32'(runderflow), 1);
    uf_clr = 1'b0; rinc = 1'b0;

    // Full and wrap
    apply_reset("reset2");
    for (int i = 0; i < (1 << ADDR); i++) mem[i] = 8'(8'h10 + i);
    set_w(4'd8);
    cycle();
    check_eq("full_rlevel", 32'(rlevel), 8);
    check_eq("full_rempty", 32'(rempty), 0);
    rinc = 1'b1;
    for (int i = 0; i < (1 << ADDR); i++) cycle();
    rinc = 1'b0;
    check_eq("wrap_rptr",   32'(rptr), 32'b1100);
    check_eq("wrap_rempty", 32'(rempty), 1);
    check_eq("wrap_raddr",  32'(raddr), 0);
    set_w(4'd9);
    cycle();
    check_eq("wrap_w9_rempty", 32'(rempty), 0);
    check_eq("wrap_w9_rlevel", 32'(rlevel), 1);

    // Random stream: writer advances pointer while reads are requested
    for (int n = 0; n < 400; n++) begin
      logic [PW-1:0] lvl;
      lvl = m_wbin - m_rbin;
      if (lvl < PW'(1 << ADDR) && $urandom_range(0, 1) == 1) begin
        mem[m_wbin[ADDR-1:0]] = 8'($urandom_range(0, 255));
        set_w(m_wbin + 1'b1);
      end
      rinc   = ($urandom_range(0, 99) < 55);
      uf_clr = ($urandom_range(0, 9) == 0);
      cycle();
    end
    rinc = 1'b0; uf_clr = 1'b0;

    // Mid-operation reset with reads streaming
    apply_reset("reset3");
    set_w(4'd5);
    cycle();
    check_eq("mid_rlevel", 32'(rlevel), 5);
    rinc = 1'b1;
    cycle();
    #2;
    apply_reset("midrst");
    cycle();
    check_eq("post_rst_rempty", 32'(rempty), 1);
    cycle();

    check_eq("exp_q_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
